// File: rtl/led_page_ctrl.sv
// -----------------------------------------------------------------------------
// led_page_ctrl
//
// Upstream feeder for the board LED byte-display stage of the R/I CPU.
// Holds the last captured CPU result word and its overflow/zero flags, and
// produces the page select for the LED mux. Pages 0-3 show one result byte
// each and page 4 shows the flags. The page advances on a debounced
// push-button press or, when enabled, on a free-running auto-scan timer.
//
// Parameters
//   DB_W        width of the debounce counter
//   DB_CYCLES   stable cycles before a new button level is accepted
//               (2 <= DB_CYCLES < 2**DB_W)
//   SCAN_W      width of the auto-scan counter
//   SCAN_CYCLES cycles per page in auto-scan mode
//               (2 <= SCAN_CYCLES < 2**SCAN_W)
//
// Ports
//   clk        system clock, all logic rising-edge
//   rst_n      synchronous active-low reset, highest priority
//   res        CPU result word
//   of_in      CPU overflow flag
//   zf_in      CPU zero flag
//   res_valid  capture strobe for res/of_in/zf_in
//   hold       1 = freeze the display register, ignore res_valid
//   btn        raw asynchronous active-high page-step button
//   auto_en    1 = automatic page scan enabled
//   sel_clr    synchronous force of the page select to 0
//   dina       held result word
//   ofa        held overflow flag
//   zfa        held zero flag
//   sela       page select, only 0-4 are ever driven
// -----------------------------------------------------------------------------
module led_page_ctrl #(
  parameter int DB_W        = 20,
  parameter int DB_CYCLES   = 1000000,
  parameter int SCAN_W      = 26,
  parameter int SCAN_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] res,
  input  logic        of_in,
  input  logic        zf_in,
  input  logic        res_valid,
  input  logic        hold,
  input  logic        btn,
  input  logic        auto_en,
  input  logic        sel_clr,
  output logic [31:0] dina,
  output logic        ofa,
  output logic        zfa,
  output logic [2:0]  sela
);

  // Page encoding seen by the LED mux. Codes 5-7 are never produced.
  typedef enum logic [2:0] {
    PG_B0    = 3'd0,
    PG_B1    = 3'd1,
    PG_B2    = 3'd2,
    PG_B3    = 3'd3,
    PG_FLAGS = 3'd4
  } page_t;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Display holding register
  // ---------------------------------------------------------------------------
  // NOTE: every register here takes a reset value; there is no memory array,
  // so nothing is left to power up in an unknown state after rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dina <= 32'd0;
      ofa  <= 1'b0;
      zfa  <= 1'b0;
    end else if (res_valid && !hold) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values
      // regardless of statement order; = here would create ordering races.
      dina <= res;
      ofa  <= of_in;
      zfa  <= zf_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchroniser: btn -> s1 -> btn_s
  // ---------------------------------------------------------------------------
  logic s1;
  logic btn_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer
  // btn_db follows btn_s only after btn_s has differed from it for DB_CYCLES
  // consecutive cycles. Any return to the current level restarts the count,
  // so short glitches never reach btn_db.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_d;
  logic            btn_db;
  logic            btn_db_d;
  logic            btn_db_q;
  logic            press;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    db_cnt_d = '0;
    btn_db_d = btn_db;
    if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db_d = btn_s;
      end else begin
        db_cnt_d = db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      db_cnt   <= db_cnt_d;
      btn_db   <= btn_db_d;
      btn_db_q <= btn_db;
    end
  end

  // One-cycle pulse on the debounced rising edge; release never steps.
  assign press = btn_db && !btn_db_q;

  // ---------------------------------------------------------------------------
  // Auto-scan timer
  // Held at 0 while disabled, so re-enabling always starts a full period.
  // A manual press or sel_clr also restarts the period.
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [SCAN_W-1:0] scan_cnt_d;
  logic              tick;

  assign tick = auto_en && (scan_cnt == SCAN_LAST);

  always_comb begin
    scan_cnt_d = scan_cnt + 1'b1;
    if (sel_clr || !auto_en || press || tick) begin
      scan_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Page select: state register plus next-state logic.
  // sel_clr wins; otherwise press and tick are OR-ed so a coincident pair
  // still advances by exactly one page.
  // ---------------------------------------------------------------------------
  page_t page_q;
  page_t page_d;

  always_comb begin
    page_d = page_q;
    if (sel_clr) begin
      page_d = PG_B0;
    end else if (press || tick) begin
      case (page_q)
        PG_B0:   page_d = PG_B1;
        PG_B1:   page_d = PG_B2;
        PG_B2:   page_d = PG_B3;
        PG_B3:   page_d = PG_FLAGS;
        default: page_d = PG_B0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page_q <= PG_B0;
    end else begin
      page_q <= page_d;
    end
  end

  assign sela = page_q;

endmodule

// File: tb/tb_led_page_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_page_ctrl
//
// Directed self-checking bench for led_page_ctrl with DB_CYCLES=4 and
// SCAN_CYCLES=8. Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, i.e. well away from the active edge.
// Expected button latency: 2 sync + 4 debounce + 1 register = 7 cycles.
// -----------------------------------------------------------------------------
module tb_led_page_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] res;
  logic        of_in;
  logic        zf_in;
  logic        res_valid;
  logic        hold;
  logic        btn;
  logic        auto_en;
  logic        sel_clr;
  logic [31:0] dina;
  logic        ofa;
  logic        zfa;
  logic [2:0]  sela;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_page_ctrl #(
    .DB_W       (4),
    .DB_CYCLES  (4),
    .SCAN_W     (4),
    .SCAN_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res      (res),
    .of_in    (of_in),
    .zf_in    (zf_in),
    .res_valid(res_valid),
    .hold     (hold),
    .btn      (btn),
    .auto_en  (auto_en),
    .sel_clr  (sel_clr),
    .dina     (dina),
    .ofa      (ofa),
    .zfa      (zfa),
    .sela     (sela)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until sela leaves prev, bounded so a dead DUT cannot hang.
  task automatic wait_step(input logic [2:0] prev, output int n);
    n = 0;
    while (sela == prev && n < 30) begin
      cyc(1);
      n++;
    end
  endtask

  int          n;
  logic [2:0]  exp_sel;

  initial begin
    rst_n     = 1'b0;
    res       = 32'd0;
    of_in     = 1'b0;
    zf_in     = 1'b0;
    res_valid = 1'b0;
    hold      = 1'b0;
    btn       = 1'b0;
    auto_en   = 1'b0;
    sel_clr   = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("init_sela", {29'd0, sela}, 32'd0);

    // ---- Preload dina=DEADBEEF, sela=3, then a single reset edge ----------
    res       = 32'hDEADBEEF;
    of_in     = 1'b1;
    zf_in     = 1'b1;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    auto_en   = 1'b1;
    cyc(24);
    auto_en   = 1'b0;
    check("pre_dina", dina, 32'hDEADBEEF);
    check("pre_sela", {29'd0, sela}, 32'd3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("rst_dina", dina, 32'd0);
    check("rst_flags", {30'd0, ofa, zfa}, 32'd0);
    check("rst_sela", {29'd0, sela}, 32'd0);

    // ---- Capture and hold -------------------------------------------------
    res       = 32'h12345678;
    of_in     = 1'b1;
    zf_in     = 1'b0;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    check("cap_dina", dina, 32'h12345678);
    check("cap_flags", {30'd0, ofa, zfa}, 32'd2);
    hold      = 1'b1;
    res       = 32'hFFFFFFFF;
    of_in     = 1'b0;
    zf_in     = 1'b1;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    hold      = 1'b0;
    check("hold_dina", dina, 32'h12345678);
    check("hold_flags", {30'd0, ofa, zfa}, 32'd2);

    // ---- Five debounced presses: 1,2,3,4,0 each 7 cycles after btn rises --
    for (int i = 0; i < 5; i++) begin
      exp_sel = 3'((i + 1) % 5);
      btn = 1'b1;
      wait_step(sela, n);
      check("btn_lat", n, 32'd7);
      check("btn_sel", {29'd0, sela}, {29'd0, exp_sel});
      if (n < 10) cyc(10 - n);
      btn = 1'b0;
      cyc(10);
      check("btn_release", {29'd0, sela}, {29'd0, exp_sel});
    end

    // ---- 3-cycle glitch must not step -------------------------------------
    btn = 1'b1;
    cyc(3);
    btn = 1'b0;
    cyc(15);
    check("glitch_sela", {29'd0, sela}, 32'd0);

    // ---- Auto-scan: a step every 8 cycles ---------------------------------
    auto_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_sel = 3'((i + 1) % 5);
      cyc(7);
      check("scan_wait", {29'd0, sela}, {29'd0, 3'(i % 5)});
      cyc(1);
      check("scan_step", {29'd0, sela}, {29'd0, exp_sel});
    end
    // Drop auto_en 4 cycles into a period; the partial count is discarded.
    cyc(4);
    auto_en = 1'b0;
    cyc(2);
    auto_en = 1'b1;
    cyc(7);
    check("rescan_wait", {29'd0, sela}, 32'd0);
    cyc(1);
    check("rescan_step", {29'd0, sela}, 32'd1);
    auto_en = 1'b0;
    cyc(2);

    // ---- Press and tick in the same cycle: exactly one step ---------------
    auto_en = 1'b1;        // tick lands on the 8th edge from here
    cyc(1);
    btn = 1'b1;            // press lands 7 edges later: the same edge
    cyc(6);
    check("coinc_before", {29'd0, sela}, 32'd1);
    cyc(1);
    check("coinc_step", {29'd0, sela}, 32'd2);
    cyc(7);
    check("coinc_next_wait", {29'd0, sela}, 32'd2);
    cyc(1);
    check("coinc_next_step", {29'd0, sela}, 32'd3);
    auto_en = 1'b0;
    btn     = 1'b0;
    cyc(10);

    // ---- sel_clr together with a press wins -------------------------------
    btn = 1'b1;
    cyc(6);
    sel_clr = 1'b1;        // press is active on the next edge
    cyc(1);
    sel_clr = 1'b0;
    check("clr_press", {29'd0, sela}, 32'd0);
    cyc(1);
    check("clr_after", {29'd0, sela}, 32'd0);
    btn = 1'b0;
    cyc(10);

    // ---- Reset mid-debounce restarts the full window ----------------------
    btn = 1'b1;
    cyc(4);                // db_cnt is 2 here
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("rst_db_sela", {29'd0, sela}, 32'd0);
    wait_step(3'd0, n);
    check("rst_db_lat", n, 32'd7);
    check("rst_db_step", {29'd0, sela}, 32'd1);
    btn = 1'b0;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
